cellram_ctrl: RTL

Two-port arbitrating controller for the board's 16-bit cellular RAM (PSRAM), run in asynchronous (SRAM-style) mode. It shares the single RAM between two requesters (e.g. image loader and pixel processor) using round-robin arbitration. It times every read and write cycle in `clk` periods and drives the RAM pins that `main` exposes. The `MemDB` tristate is resolved in `main` from `dq_o` / `dq_oe` / `dq_i`.

---
 rtl/cellram_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cellram_ctrl.sv
// cellram_ctrl
// Two-port arbitrating controller for the board's 16-bit cellular RAM used in
// asynchronous (SRAM-style) mode. Two requesters share the RAM through
// round-robin arbitration; every read and write is timed in clk periods.
//
// Ports:
//   clk, rstn              system clock, synchronous active-low reset
//   req, we                per-port request / write-not-read (bit N = port N)
//   addr0/1, wdata0/1      per-port word address and write data
//   be0/1                  per-port byte enables ([0] low byte, [1] high byte)
//   ack                    one-cycle completion pulse to the served port
//   rdata                  last completed read data (disabled bytes are zero)
//   RamCLK/RamADVn/RamCRE  tied low for async mode
//   RamCEn/OEn/WEn/LBn/UBn registered active-low RAM strobes
//   RamWait                unused in async mode
//   MemAdr                 registered RAM word address
//   dq_o, dq_oe, dq_i      data bus out, output enable, sampled bus in
module cellram_ctrl #(
  parameter int unsigned RD_CYCLES = 8,
  parameter int unsigned WR_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [22:0] addr0,
  input  logic [22:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        RamCLK,
  output logic        RamADVn,
  output logic        RamCRE,
  output logic        RamCEn,
  output logic        RamOEn,
  output logic        RamWEn,
  output logic        RamLBn,
  output logic        RamUBn,
  input  logic        RamWait,
  output logic [22:0] MemAdr,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  input  logic [15:0] dq_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, REC} CtrlState;

  // The counter holds "cycles remaining minus one", so it is loaded with N-1.
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

  CtrlState    state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic        last, lastNext;
  logic [1:0]  beLat, beLatNext;
  logic        grant;
  logic [1:0]  grantBe;

  logic        ramCEnNext, ramOEnNext, ramWEnNext, ramLBnNext, ramUBnNext;
  logic [22:0] memAdrNext;
  logic [15:0] dqONext;
  logic        dqOeNext;
  logic [1:0]  ackNext;
  logic [15:0] rdataNext;

  logic        unusedRamWait;

  // Async mode: no clocked bursts, no address-valid strobe, no config access.
  assign RamCLK  = 1'b0;
  assign RamADVn = 1'b0;
  assign RamCRE  = 1'b0;
  assign unusedRamWait = RamWait;

  // Round-robin pick: a lone requester always wins; under contention the
  // port that was not served last time gets the RAM.
  assign grant   = (&req) ? ~last : req[1];
  assign grantBe = grant ? be1 : be0;

  // Next-state and next-output logic. Every RAM-facing output is computed
  // here one cycle ahead and registered below, so nothing reaches a pin
  // combinationally. The winner's address, data and byte enables are
  // captured at the grant edge and then held untouched until the access
  // retires, which keeps setup and hold at whole-cycle granularity.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    lastNext   = last;
    beLatNext  = beLat;
    ramCEnNext = RamCEn;
    ramOEnNext = RamOEn;
    ramWEnNext = RamWEn;
    ramLBnNext = RamLBn;
    ramUBnNext = RamUBn;
    memAdrNext = MemAdr;
    dqONext    = dq_o;
    dqOeNext   = dq_oe;
    ackNext    = 2'b00;
    rdataNext  = rdata;

    case (state)
      IDLE: begin
        ramCEnNext = 1'b1;
        ramOEnNext = 1'b1;
        ramWEnNext = 1'b1;
        ramLBnNext = 1'b1;
        ramUBnNext = 1'b1;
        dqOeNext   = 1'b0;
        if (|req) begin
          lastNext   = grant;
          beLatNext  = grantBe;
          memAdrNext = grant ? addr1 : addr0;
          dqONext    = grant ? wdata1 : wdata0;
          ramCEnNext = 1'b0;
          ramLBnNext = ~grantBe[0];
          ramUBnNext = ~grantBe[1];
          if (we[grant]) begin
            ramWEnNext = 1'b0;
            dqOeNext   = 1'b1;
            cntNext    = WR_LOAD;
            stateNext  = WR;
          end else begin
            ramOEnNext = 1'b0;
            cntNext    = RD_LOAD;
            stateNext  = RD;
          end
        end
      end

      // 'last' already names the port being served, so it steers ack.
      // Read data is captured on the same edge the strobes are released.
      RD, WR: begin
        if (cnt == 4'd0) begin
          ramCEnNext   = 1'b1;
          ramOEnNext   = 1'b1;
          ramWEnNext   = 1'b1;
          ramLBnNext   = 1'b1;
          ramUBnNext   = 1'b1;
          ackNext[last] = 1'b1;
          if (state == RD) begin
            rdataNext = {beLat[1] ? dq_i[15:8] : 8'h00,
                         beLat[0] ? dq_i[7:0]  : 8'h00};
          end
          stateNext = REC;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end

      // Recovery cycle: write data keeps being driven for hold time, then
      // the bus is released on the way back to IDLE.
      REC: begin
        dqOeNext  = 1'b0;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  // State and output registers. Reset also aborts any access in flight:
  // strobes rise at that edge and no ack is issued for it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last   <= 1'b1;
      beLat  <= 2'b00;
      RamCEn <= 1'b1;
      RamOEn <= 1'b1;
      RamWEn <= 1'b1;
      RamLBn <= 1'b1;
      RamUBn <= 1'b1;
      MemAdr <= 23'd0;
      dq_o   <= 16'd0;
      dq_oe  <= 1'b0;
      ack    <= 2'b00;
      rdata  <= 16'd0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      last   <= lastNext;
      beLat  <= beLatNext;
      RamCEn <= ramCEnNext;
      RamOEn <= ramOEnNext;
      RamWEn <= ramWEnNext;
      RamLBn <= ramLBnNext;
      RamUBn <= ramUBnNext;
      MemAdr <= memAdrNext;
      dq_o   <= dqONext;
      dq_oe  <= dqOeNext;
      ack    <= ackNext;
      rdata  <= rdataNext;
    end
  end

endmodule
